// File: rtl/skein_dispatch_pkg.sv
// Shared types and constants for the multi-core Skein dispatcher.
package skein_dispatch_pkg;

  localparam int unsigned DefNonceW = 256;
  localparam int unsigned DefHashW  = 1024;

  // Width needed to count every bit of a hash_w-bit vector (0..hash_w inclusive).
  function automatic int unsigned score_width(input int unsigned hash_w);
    return $clog2(hash_w + 1);
  endfunction

  localparam int unsigned DefScoreW = score_width(DefHashW);

  // Worst possible score; the search restarts from here.
  localparam logic [DefScoreW-1:0] BestScoreRst = '1;

  typedef enum logic {
    CoreIdle,
    CoreBusy
  } core_state_e;

endpackage

// File: rtl/skein_rr_arbiter.sv
// Round-robin arbiter: request vector to one-hot grant. The search starts at the
// pointer and wraps; after a grant the pointer moves to one past the winner.
module skein_rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              gnt_valid_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            hit_hi, hit_lo;
  int              idx_hi, idx_lo, gnt_idx;

  // Pick lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = 0;
    idx_lo = 0;
    // Walk downwards so the last hit written is the lowest index.
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        hit_lo = 1'b1;
        idx_lo = i;
        if (i >= int'(ptr_q)) begin
          hit_hi = 1'b1;
          idx_hi = i;
        end
      end
    end
    gnt_idx     = hit_hi ? idx_hi : idx_lo;
    gnt_valid_o = hit_lo;
    for (int i = 0; i < int'(NumReq); i++) begin
      gnt_o[i] = hit_lo && (i == gnt_idx);
    end
    ptr_d = ptr_q;
    if (hit_lo) begin
      ptr_d = (gnt_idx == int'(NumReq) - 1) ? '0 : PtrW'(gnt_idx + 1);
    end
  end

  // Rotating priority pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/skein_multi_core_dispatch.sv
// Multi-core Skein dispatcher: hands consecutive nonces to idle cores, collects
// hashes round-robin, scores them by Hamming distance to the target through a
// three-stage pipeline and keeps the best (score, nonce) for the serial side.
// Optional: define SKEIN_THRESHOLD_STOP_EN to add stop_threshold_i/threshold_hit_o,
// which halt dispatch once any score reaches the threshold.
module skein_multi_core_dispatch
  import skein_dispatch_pkg::*;
#(
  parameter int unsigned NumCores = 4,
  parameter int unsigned NonceW   = DefNonceW,
  parameter int unsigned HashW    = DefHashW,
  parameter int unsigned ScoreW   = score_width(HashW)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       nonce_load_i,
  input  logic [NonceW-1:0]          nonce_seed_i,
  input  logic [HashW-1:0]           target_i,
  output logic [NumCores-1:0]        core_start_o,
  output logic [NumCores*NonceW-1:0] core_nonce_o,
  input  logic [NumCores-1:0]        core_done_i,
  input  logic [NumCores*HashW-1:0]  core_hash_i,
  output logic [NumCores-1:0]        core_ack_o,
`ifdef SKEIN_THRESHOLD_STOP_EN
  input  logic [ScoreW-1:0]          stop_threshold_i,
  output logic                       threshold_hit_o,
`endif
  output logic                       best_valid_o,
  output logic [ScoreW-1:0]          best_score_o,
  output logic [NonceW-1:0]          best_nonce_o,
  input  logic                       best_ack_i,
  output logic                       idle_o
);

  localparam logic [ScoreW-1:0] ScoreRst = '1;

  core_state_e       core_state_q [NumCores];
  core_state_e       core_state_d [NumCores];
  logic [NonceW-1:0] core_nonce_q [NumCores];
  logic [NonceW-1:0] core_nonce_d [NumCores];
  logic [NonceW-1:0] counter_q, counter_d;

  logic [NumCores-1:0] busy, req;
  logic                gnt_valid;
  logic                halt;
  logic                dispatch_ok;
  logic                dispatched;

  logic              s1_valid_q;
  logic [HashW-1:0]  s1_xor_q, s1_xor_d;
  logic [NonceW-1:0] s1_nonce_q, s1_nonce_d;
  logic              s2_valid_q;
  logic [ScoreW-1:0] s2_score_q, s2_score_d;
  logic [NonceW-1:0] s2_nonce_q;

  logic              best_valid_q, best_valid_d;
  logic [ScoreW-1:0] best_score_q, best_score_d;
  logic [NonceW-1:0] best_nonce_q, best_nonce_d;
  logic              improve;

`ifdef SKEIN_THRESHOLD_STOP_EN
  logic thr_hit_q, thr_hit_d;

  // Latch a threshold hit until the search is restarted.
  always_comb begin
    thr_hit_d = thr_hit_q;
    if (nonce_load_i) begin
      thr_hit_d = 1'b0;
    end else if (s2_valid_q && (s2_score_q <= stop_threshold_i)) begin
      thr_hit_d = 1'b1;
    end
  end

  // Threshold-hit flag register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      thr_hit_q <= 1'b0;
    end else begin
      thr_hit_q <= thr_hit_d;
    end
  end

  assign threshold_hit_o = thr_hit_q;
  assign halt            = thr_hit_q;
`else
  assign halt = 1'b0;
`endif

  // Request vector for collection: only busy cores may report a hash.
  always_comb begin
    for (int i = 0; i < int'(NumCores); i++) begin
      busy[i] = (core_state_q[i] == CoreBusy);
    end
    req = busy & core_done_i;
  end

  skein_rr_arbiter #(
    .NumReq (NumCores)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_i),
    .req_i       (req),
    .gnt_o       (core_ack_o),
    .gnt_valid_o (gnt_valid)
  );

  assign dispatch_ok = enable_i && !nonce_load_i && !halt;

  // Core FSMs and dispatch: start the lowest-index idle core, at most one per cycle.
  always_comb begin
    core_start_o = '0;
    dispatched   = 1'b0;
    counter_d    = counter_q;
    for (int i = 0; i < int'(NumCores); i++) begin
      core_state_d[i] = core_state_q[i];
      core_nonce_d[i] = core_nonce_q[i];
    end
    for (int i = 0; i < int'(NumCores); i++) begin
      if (dispatch_ok && !dispatched && (core_state_q[i] == CoreIdle)) begin
        core_start_o[i] = 1'b1;
        dispatched      = 1'b1;
        core_state_d[i] = CoreBusy;
        core_nonce_d[i] = counter_q;
      end else if (core_ack_o[i]) begin
        core_state_d[i] = CoreIdle;
      end
    end
    if (nonce_load_i) begin
      counter_d = nonce_seed_i;
    end else if (dispatched) begin
      counter_d = counter_q + NonceW'(1);
    end
  end

  // Core state, per-core nonces and the nonce counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      counter_q <= '0;
      for (int i = 0; i < int'(NumCores); i++) begin
        core_state_q[i] <= CoreIdle;
        core_nonce_q[i] <= '0;
      end
    end else begin
      counter_q <= counter_d;
      for (int i = 0; i < int'(NumCores); i++) begin
        core_state_q[i] <= core_state_d[i];
        core_nonce_q[i] <= core_nonce_d[i];
      end
    end
  end

  // Flatten per-core nonces onto the output bus.
  always_comb begin
    for (int i = 0; i < int'(NumCores); i++) begin
      core_nonce_o[i*NonceW +: NonceW] = core_nonce_q[i];
    end
  end

  // Stage 1 input mux: granted core's hash XOR target, plus its nonce.
  always_comb begin
    s1_xor_d   = '0;
    s1_nonce_d = '0;
    for (int i = 0; i < int'(NumCores); i++) begin
      if (core_ack_o[i]) begin
        s1_xor_d   = core_hash_i[i*HashW +: HashW] ^ target_i;
        s1_nonce_d = core_nonce_q[i];
      end
    end
  end

  // Stage 2 input: popcount of the difference vector.
  always_comb begin
    s2_score_d = '0;
    for (int b = 0; b < int'(HashW); b++) begin
      s2_score_d = s2_score_d + ScoreW'(s1_xor_q[b]);
    end
  end

  // Scoring pipeline registers. A load drops results already in flight; a hash
  // granted in the load cycle itself is kept and scores against the reset best.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid_q <= 1'b0;
      s1_xor_q   <= '0;
      s1_nonce_q <= '0;
      s2_valid_q <= 1'b0;
      s2_score_q <= '0;
      s2_nonce_q <= '0;
    end else begin
      s1_valid_q <= gnt_valid;
      s1_xor_q   <= s1_xor_d;
      s1_nonce_q <= s1_nonce_d;
      s2_valid_q <= s1_valid_q && !nonce_load_i;
      s2_score_q <= s2_score_d;
      s2_nonce_q <= s1_nonce_q;
    end
  end

  // Stage 3: strict improvement keeps the earlier result on ties.
  always_comb begin
    improve      = s2_valid_q && (s2_score_q < best_score_q);
    best_valid_d = best_valid_q;
    best_score_d = best_score_q;
    best_nonce_d = best_nonce_q;
    if (nonce_load_i) begin
      best_valid_d = 1'b0;
      best_score_d = ScoreRst;
    end else if (improve) begin
      best_valid_d = 1'b1;
      best_score_d = s2_score_q;
      best_nonce_d = s2_nonce_q;
    end else if (best_ack_i) begin
      best_valid_d = 1'b0;
    end
  end

  // Best-result registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      best_valid_q <= 1'b0;
      best_score_q <= ScoreRst;
      best_nonce_q <= '0;
    end else begin
      best_valid_q <= best_valid_d;
      best_score_q <= best_score_d;
      best_nonce_q <= best_nonce_d;
    end
  end

  assign best_valid_o = best_valid_q;
  assign best_score_o = best_score_q;
  assign best_nonce_o = best_nonce_q;
  assign idle_o       = !(|busy) && !s1_valid_q && !s2_valid_q;

endmodule

// File: tb/tb_skein_multi_core_dispatch.sv
// Bench for skein_multi_core_dispatch at default parameters (4 cores, 256/1024 bits).
// Stimulus plays the role of the cores; a monitor pops expected starts, acks and
// best results from queues whenever the DUT presents one.
module tb_skein_multi_core_dispatch;

  localparam int NC = 4;
  localparam int NW = 256;
  localparam int HW = 1024;
  localparam int SW = 11;

  typedef struct {
    int            idx;
    logic [NW-1:0] nonce;
  } start_t;

  typedef struct {
    logic [SW-1:0] score;
    logic [NW-1:0] nonce;
  } best_t;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             enable;
  logic             nonce_load;
  logic [NW-1:0]    nonce_seed;
  logic [HW-1:0]    target;
  logic [NC-1:0]    core_start;
  logic [NC*NW-1:0] core_nonce;
  logic [NC-1:0]    core_done;
  logic [NC*HW-1:0] core_hash;
  logic [NC-1:0]    core_ack;
  logic             best_valid;
  logic [SW-1:0]    best_score;
  logic [NW-1:0]    best_nonce;
  logic             best_ack;
  logic             idle;
`ifdef SKEIN_THRESHOLD_STOP_EN
  logic [SW-1:0]    stop_threshold;
  logic             threshold_hit;
`endif

  int n_chk = 0;
  int n_err = 0;

  start_t q_start[$];
  int     q_ack[$];
  best_t  q_best[$];

  always #5 clk = ~clk;

  skein_multi_core_dispatch dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable),
    .nonce_load_i (nonce_load),
    .nonce_seed_i (nonce_seed),
    .target_i     (target),
    .core_start_o (core_start),
    .core_nonce_o (core_nonce),
    .core_done_i  (core_done),
    .core_hash_i  (core_hash),
    .core_ack_o   (core_ack),
`ifdef SKEIN_THRESHOLD_STOP_EN
    .stop_threshold_i (stop_threshold),
    .threshold_hit_o  (threshold_hit),
`endif
    .best_valid_o (best_valid),
    .best_score_o (best_score),
    .best_nonce_o (best_nonce),
    .best_ack_i   (best_ack),
    .idle_o       (idle)
  );

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // End the current cycle; cores drop done once their ack has been seen.
  task automatic tick();
    logic [NC-1:0] acked;
    @(negedge clk);
    acked = core_ack;
    @(posedge clk);
    #1;
    core_done = core_done & ~acked;
  endtask

  task automatic set_hash(input int i, input logic [31:0] mask);
    core_hash[i*HW +: HW] = target ^ {{(HW-32){1'b0}}, mask};
  endtask

  task automatic push_start(input int i, input logic [NW-1:0] n);
    start_t s;
    s.idx   = i;
    s.nonce = n;
    q_start.push_back(s);
  endtask

  task automatic push_best(input logic [SW-1:0] sc, input logic [NW-1:0] n);
    best_t b;
    b.score = sc;
    b.nonce = n;
    q_best.push_back(b);
  endtask

  task automatic monitor();
    start_t        s;
    best_t         b;
    int            a;
    logic          pend;
    int            pidx;
    logic [NW-1:0] pnon;
    logic          pv;
    logic [SW-1:0] ps;
    logic [NW-1:0] pn;
    pend = 1'b0;
    pidx = 0;
    pnon = '0;
    pv   = 1'b0;
    ps   = '1;
    pn   = '0;
    forever begin
      @(negedge clk);
      // Nonce is registered at dispatch, so it shows the cycle after the start pulse.
      if (pend) begin
        chk("start_nonce", core_nonce[pidx*NW +: NW], pnon);
        pend = 1'b0;
      end
      if (core_start != '0) begin
        if (q_start.size() == 0) begin
          chk("unexpected_start", NW'(core_start), '0);
        end else begin
          s = q_start.pop_front();
          chk("start_core", NW'(core_start), NW'(1) << s.idx);
          pend = 1'b1;
          pidx = s.idx;
          pnon = s.nonce;
        end
      end
      if (core_ack != '0) begin
        if (q_ack.size() == 0) begin
          chk("unexpected_ack", NW'(core_ack), '0);
        end else begin
          a = q_ack.pop_front();
          chk("ack_core", NW'(core_ack), NW'(1) << a);
        end
      end
      if (best_valid && (!pv || best_score != ps || best_nonce != pn)) begin
        if (q_best.size() == 0) begin
          chk("unexpected_best", NW'(best_score), '1);
        end else begin
          b = q_best.pop_front();
          chk("best_score", NW'(best_score), NW'(b.score));
          chk("best_nonce", best_nonce, b.nonce);
        end
      end
      pv = best_valid;
      ps = best_score;
      pn = best_nonce;
    end
  endtask

  initial begin
    rst_i      = 1'b0;
    enable     = 1'b0;
    nonce_load = 1'b0;
    nonce_seed = '0;
    target     = {16{64'hA5A5_5A5A_0F0F_F0F0}};
    core_done  = '0;
    core_hash  = '0;
    best_ack   = 1'b0;
`ifdef SKEIN_THRESHOLD_STOP_EN
    stop_threshold = '0;
`endif
    fork
      monitor();
    join_none

    // Reset state.
    #22;
    chk("rst_start", NW'(core_start), '0);
    chk("rst_ack", NW'(core_ack), '0);
    chk("rst_best_valid", NW'(best_valid), '0);
    chk("rst_best_score", NW'(best_score), NW'(11'h7FF));
    chk("rst_best_nonce", best_nonce, '0);
    chk("rst_core_nonce", core_nonce[NW-1:0], '0);
    chk("rst_idle", NW'(idle), NW'(1));
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    // Seed 0x10, four consecutive dispatches.
    nonce_load = 1'b1;
    nonce_seed = NW'(16'h10);
    enable     = 1'b1;
    tick();
    nonce_load = 1'b0;
    for (int i = 0; i < NC; i++) push_start(i, NW'(16'h10 + i));
    for (int i = 0; i < NC; i++) tick();
    enable = 1'b0;
    chk("idle_busy", NW'(idle), '0);

    // Core 2 done, score 3: acked at once, result visible three cycles later.
    core_done[2] = 1'b1;
    set_hash(2, 32'h7);
    q_ack.push_back(2);
    push_best(SW'(3), NW'(16'h12));
    #1;
    chk("ack2_same_cycle", NW'(core_ack), NW'(4'b0100));
    tick();
    tick();
    chk("best_not_yet", NW'(best_valid), '0);
    tick();
    chk("best_valid_t3", NW'(best_valid), NW'(1));
    chk("best_score_t3", NW'(best_score), NW'(3));
    chk("best_nonce_t3", best_nonce, NW'(16'h12));
    best_ack = 1'b1;
    tick();
    best_ack = 1'b0;
    chk("best_acked", NW'(best_valid), '0);

    // Core 3 done with score 8: no improvement; pointer wraps back to core 0.
    core_done[3] = 1'b1;
    set_hash(3, 32'hFF);
    q_ack.push_back(3);
    for (int i = 0; i < 4; i++) tick();
    chk("no_improve_score", NW'(best_score), NW'(3));
    chk("no_improve_valid", NW'(best_valid), '0);

    // Redispatch cores 2 and 3.
    enable = 1'b1;
    push_start(2, NW'(16'h14));
    push_start(3, NW'(16'h15));
    tick();
    tick();
    enable = 1'b0;

    // All done together: acks 0,1,2,3; core 1 wins, core 2 ties and loses.
    set_hash(0, 32'h1F);
    set_hash(1, 32'h3);
    set_hash(2, 32'h300);
    set_hash(3, 32'h3F);
    core_done = 4'b1111;
    for (int i = 0; i < NC; i++) q_ack.push_back(i);
    push_best(SW'(2), NW'(16'h11));
    for (int i = 0; i < 8; i++) tick();
    chk("tie_score", NW'(best_score), NW'(2));
    chk("tie_nonce", best_nonce, NW'(16'h11));
    chk("tie_valid", NW'(best_valid), NW'(1));

    // Ack in the same cycle as an improvement to score 1.
    enable = 1'b1;
    push_start(0, NW'(16'h16));
    tick();
    enable       = 1'b0;
    core_done[0] = 1'b1;
    set_hash(0, 32'h1);
    q_ack.push_back(0);
    push_best(SW'(1), NW'(16'h16));
    tick();
    tick();
    best_ack = 1'b1;
    tick();
    best_ack = 1'b0;
    chk("ack_improve_valid", NW'(best_valid), NW'(1));
    chk("ack_improve_score", NW'(best_score), NW'(1));
    chk("ack_improve_nonce", best_nonce, NW'(16'h16));

    // Load while cores 0,1 busy; their results score against the reset best.
    enable = 1'b1;
    push_start(0, NW'(16'h17));
    push_start(1, NW'(16'h18));
    tick();
    tick();
    enable     = 1'b0;
    nonce_load = 1'b1;
    nonce_seed = '1;
    tick();
    nonce_load = 1'b0;
    chk("load_valid", NW'(best_valid), '0);
    chk("load_score", NW'(best_score), NW'(11'h7FF));
    set_hash(0, 32'h1FF);
    set_hash(1, 32'h3FF);
    core_done = 4'b0011;
    q_ack.push_back(1);
    q_ack.push_back(0);
    push_best(SW'(10), NW'(16'h18));
    push_best(SW'(9), NW'(16'h17));
    for (int i = 0; i < 6; i++) tick();
    chk("post_load_score", NW'(best_score), NW'(9));
    chk("post_load_nonce", best_nonce, NW'(16'h17));
    chk("post_load_valid", NW'(best_valid), NW'(1));
    chk("idle_drained", NW'(idle), NW'(1));

    // Counter wrap: seed all ones gives 2^256-1 then 0.
    enable = 1'b1;
    push_start(0, '1);
    push_start(1, '0);
    tick();
    tick();
    enable = 1'b0;
    tick();
    tick();
    chk("idle_after_wrap", NW'(idle), '0);

    chk("start_q_empty", NW'(q_start.size()), '0);
    chk("ack_q_empty", NW'(q_ack.size()), '0);
    chk("best_q_empty", NW'(q_best.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/skein_multi_core_dispatch.md
Name: skein_multi_core_dispatch

Overview:
Parametrised successor to the single-core Skein top-level datapath. It feeds NUM_CORES Skein cores with consecutive nonces and collects their 1024-bit hashes through a round-robin arbiter. Each hash is scored by Hamming distance to a target. The block keeps the best (lowest) score and its nonce, and offers the pair to the serial interface through a valid/ack handshake.

Parameters:
NUM_CORES, 4, number of attached cores (1..16)
NONCE_W, 256, nonce width in bits
HASH_W, 1024, hash/target width in bits
SCORE_W, $clog2(HASH_W+1), Hamming score width (11 at defaults)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous, active-low reset
enable_i  in  1  permit new dispatches
nonce_load_i  in  1  one-cycle strobe: load seed, restart search
nonce_seed_i  in  NONCE_W  starting nonce
target_i  in  HASH_W  target hash, quasi-static
core_start_o  out  NUM_CORES  one-cycle start pulse per core
core_nonce_o  out  NUM_CORES*NONCE_W  per-core nonce, held while core busy
core_done_i  in  NUM_CORES  level; core hash valid, held until acked
core_hash_i  in  NUM_CORES*HASH_W  per-core hash
core_ack_o  out  NUM_CORES  one-cycle pulse: hash consumed
best_valid_o  out  1  improved result pending
best_score_o  out  SCORE_W  best Hamming distance
best_nonce_o  out  NONCE_W  nonce that produced best_score_o
best_ack_i  in  1  serial interface consumed result
idle_o  out  1  all cores idle and score pipeline empty

Behaviour:
- Reset values:
  - all core states IDLE; core_start_o, core_ack_o, best_valid_o = 0
  - core_nonce_o, best_nonce_o, nonce counter = 0
  - best_score_o = all ones; pipeline valids = 0; idle_o = 1
- Per-core FSM, IDLE -> BUSY -> IDLE:
  - IDLE->BUSY on dispatch: core_start_o[i]=1 for that cycle; core_nonce_o[i] <= counter, stable until next dispatch.
  - BUSY->IDLE on the cycle core_ack_o[i]=1.
  - core_done_i on an IDLE core is ignored.
- Dispatch:
  - At most one core per cycle: the lowest-index IDLE core, when enable_i=1 and nonce_load_i=0.
  - Counter += 1 per dispatch, modulo 2^NONCE_W; wraps silently.
- Collection:
  - Round-robin arbiter over BUSY & core_done_i.
  - Pointer starts at core 0 and advances to one past the granted index.
  - Grant in cycle t: core_ack_o[i]=1 in cycle t. Stage 1 registers (core_hash_i[i] XOR target_i, core_nonce_o[i]) at the end of t.
  - A core acked in cycle t is not dispatch-eligible until t+1.
- Scoring pipeline:
  - Stage 2 registers the popcount at the end of t+1.
  - Stage 3 compares at the end of t+2. If score < best_score_o (strict; ties keep the earlier result), update best_score_o and best_nonce_o and set best_valid_o. Visible from t+3.
  - One result per cycle throughput; no stalls.
- Handshake:
  - best_valid_o stays high until best_ack_i is sampled high; then clears the next cycle.
  - Ack and improvement in the same cycle: best_valid_o stays 1 and the new values are presented.
  - Improvement while pending: values overwrite, valid stays 1.
- nonce_load_i:
  - counter <= nonce_seed_i; best_score_o <= all ones; best_valid_o <= 0; pipeline valids flushed.
  - Busy cores keep their nonces and complete normally; their results score against the reset best.
- enable_i=0: no dispatch; in-flight cores still acked and scored.
- idle_o = no BUSY core and no pipeline valid.
- Async reset mid-operation returns everything to the reset values immediately; in-flight results are lost.

Optional Feature:
SKEIN_THRESHOLD_STOP_EN
- Enabled:
  - Adds input stop_threshold_i [SCORE_W] and output threshold_hit_o.
  - When a stage-3 score <= stop_threshold_i, threshold_hit_o latches 1 and dispatch halts as if enable_i=0.
  - Cleared by nonce_load_i or reset.
- Disabled: neither port exists; the search runs until enable_i drops.

Decomposition:
- Package skein_dispatch_pkg holds:
  - default NONCE_W, HASH_W
  - the score-width function
  - core state enum (CORE_IDLE, CORE_BUSY)
  - the all-ones best-score reset constant
- One sub-module: skein_rr_arbiter (parametrised request vector to one-hot grant, rotating pointer, reset to 0).
- Popcount stays inline.

Test Plan:
- Reset, seed=0x10, enable_i=1, NUM_CORES=4 -> core_start_o pulses cores 0,1,2,3 on consecutive cycles with nonces 0x10..0x13; idle_o=0.
- Core 2 asserts done with hash = target XOR 0x7 -> core_ack_o[2] the same cycle; best_score_o=3, best_nonce_o=0x12, best_valid_o=1 three cycles later.
- All cores done the same cycle -> acks in order 0,1,2,3 on consecutive cycles; a later tie does not replace the earlier best.
- best_ack_i asserted in the same cycle a better score (1) commits -> best_valid_o remains 1 with score 1.
- Seed = all ones, two dispatches -> nonces 2^256-1 then 0.
- nonce_load_i while cores busy -> best_valid_o=0 and best_score_o=all ones next cycle; in-flight results still scored.
